// File: rtl/ysyx_24100006_inst_imm_encoder.sv
// RV32I instruction packer: fields + immediate -> 32-bit word, queued in a 2-entry output FIFO.
// Range checking, out_err and err_cnt are live only when YSYX_24100006_IMM_CHECK_EN is defined.
module ysyx_24100006_inst_imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_imm_type,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    logic [1:0]  count;
    logic        wrPtr;
    logic        rdPtr;
    logic [31:0] instMem [2];
    logic [31:0] encInst;
    logic        push;
    logic        pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_inst  = instMem[rdPtr];

    always_comb begin
        encInst      = '0;
        encInst[6:0] = in_opcode;
        case (in_imm_type)
            3'b000: begin
                encInst[31:20] = in_imm[11:0];
                encInst[19:15] = in_rs1;
                encInst[14:12] = in_funct3;
                encInst[11:7]  = in_rd;
            end
            3'b001: begin
                encInst[31]    = in_imm[20];
                encInst[30:21] = in_imm[10:1];
                encInst[20]    = in_imm[11];
                encInst[19:12] = in_imm[19:12];
                encInst[11:7]  = in_rd;
            end
            3'b010: begin
                encInst[31:25] = in_imm[11:5];
                encInst[24:20] = in_rs2;
                encInst[19:15] = in_rs1;
                encInst[14:12] = in_funct3;
                encInst[11:7]  = in_imm[4:0];
            end
            3'b011: begin
                encInst[31]    = in_imm[12];
                encInst[30:25] = in_imm[10:5];
                encInst[24:20] = in_rs2;
                encInst[19:15] = in_rs1;
                encInst[14:12] = in_funct3;
                encInst[11:8]  = in_imm[4:1];
                encInst[7]     = in_imm[11];
            end
            default: begin
                encInst[31:12] = in_imm[31:12];
                encInst[11:7]  = in_rd;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                instMem[i] <= '0;
            end
        end else begin
            if (push) begin
                instMem[wrPtr] <= encInst;
                wrPtr          <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef YSYX_24100006_IMM_CHECK_EN
    logic       immErr;
    logic       errMem [2];
    logic [7:0] errCnt;

    // Error means the immediate does not survive truncation to the field width.
    always_comb begin
        immErr = 1'b0;
        case (in_imm_type)
            3'b000, 3'b010: immErr = !((in_imm[31:11] == '0) || (in_imm[31:11] == '1));
            3'b011: immErr = !((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) || in_imm[0];
            3'b001: immErr = !((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) || in_imm[0];
            default: immErr = (in_imm[11:0] != '0);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCnt <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                errMem[i] <= 1'b0;
            end
        end else if (push) begin
            errMem[wrPtr] <= immErr;
            if (immErr && (errCnt != '1)) begin
                errCnt <= errCnt + 8'd1;
            end
        end
    end

    assign out_err = errMem[rdPtr];
    assign err_cnt = errCnt;
`else
    assign out_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_24100006_inst_imm_encoder.sv
// Scoreboard bench for ysyx_24100006_inst_imm_encoder: each accepted request queues an expected
// entry, and a monitor decodes every popped word with the ID immediate extractor.
module tb_ysyx_24100006_inst_imm_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_imm_type = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;

    ysyx_24100006_inst_imm_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_type(in_imm_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] dimm;
        logic        err;
        logic        hasExact;
        logic [31:0] exact;
    } exp_t;

    exp_t        sb[$];
    int unsigned popCyc[$];
    int unsigned cyc = 0;
    int unsigned lastAcceptCyc = 0;
    int          nVec = 0;
    int          nMis = 0;
    int          modelErrCnt = 0;
    logic        stopTog = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic signed [31:0] s;
        s = $signed(v << (32 - n));
        return s >>> (32 - n);
    endfunction

    // Value the immediate takes once squeezed into the type's field (what ID will read back).
    function automatic logic [31:0] fitImm(input logic [2:0] t, input logic [31:0] imm);
        if (t[2]) return imm & 32'hFFFF_F000;
        case (t[1:0])
            2'b00, 2'b10: return sext(imm, 12);
            2'b11:        return sext(imm, 13) & 32'hFFFF_FFFE;
            default:      return sext(imm, 21) & 32'hFFFF_FFFE;
        endcase
    endfunction

    function automatic logic [31:0] decodeImm(input logic [2:0] t, input logic [31:0] i);
        if (t[2]) return {i[31:12], 12'h000};
        case (t[1:0])
            2'b00:   return sext({20'h0, i[31:20]}, 12);
            2'b10:   return sext({20'h0, i[31:25], i[11:7]}, 12);
            2'b11:   return sext({19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            default: return sext({11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        nVec++;
        if (got !== req) begin
            nMis++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid && ready is seen here.
    always @(negedge clk) begin
        exp_t        e;
        logic        ok;
        logic [31:0] i;
        if (!reset && out_valid && out_ready) begin
            popCyc.push_back(cyc + 1);
            nVec++;
            if (sb.size() == 0) begin
                nMis++;
                $display("FAIL unexpected_output: got inst=%h, required no entry", out_inst);
            end else begin
                e  = sb.pop_front();
                i  = out_inst;
                ok = (i[6:0] == e.op) && (decodeImm(e.t, i) == e.dimm) && (out_err === e.err);
                if (e.t[2] || e.t[1:0] == 2'b00 || e.t[1:0] == 2'b01)
                    ok = ok && (i[11:7] == e.rd);
                if (!e.t[2] && e.t[1:0] != 2'b01)
                    ok = ok && (i[14:12] == e.f3) && (i[19:15] == e.rs1);
                if (!e.t[2] && e.t[1])
                    ok = ok && (i[24:20] == e.rs2);
                if (e.hasExact)
                    ok = ok && (i == e.exact);
                if (!ok) begin
                    nMis++;
                    $display("FAIL entry type=%b: got inst=%h imm=%h err=%b, required imm=%h err=%b exact=%h",
                             e.t, i, decodeImm(e.t, i), out_err, e.dimm, e.err, e.exact);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid dropped.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic hasExact, input logic [31:0] exact);
        exp_t e;
        int   n;
        in_imm_type = t; in_opcode = op; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                nVec++; nMis++;
                $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, required 1");
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        e.t = t; e.op = op; e.f3 = f3; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.dimm = fitImm(t, imm);
        e.hasExact = hasExact; e.exact = exact;
`ifdef YSYX_24100006_IMM_CHECK_EN
        e.err = (e.dimm != imm);
        if (e.err && modelErrCnt < 255) modelErrCnt++;
`else
        e.err = 1'b0;
`endif
        sb.push_back(e);
        lastAcceptCyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        nVec++;
        if (sb.size() != 0) begin
            nMis++;
            $display("FAIL drain_timeout: got %0d entries pending, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  t;
        logic [31:0] imm;

        #12;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_inst", out_inst, 32'h0);
        check("reset_out_err", {31'b0, out_err}, 32'd0);
        check("reset_err_cnt", {24'b0, err_cnt}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // One-cycle latency from accept to head.
        out_ready = 1'b0;
        send(3'b000, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093);
        check("latency_out_valid", {31'b0, out_valid}, 32'd1);
        check("latency_out_inst", out_inst, 32'hFFF0_0093);
        check("latency_out_err", {31'b0, out_err}, 32'd0);
        out_ready = 1'b1;
        drain();

        send(3'b001, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF);
        send(3'b011, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3);
        send(3'b100, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
        send(3'b100, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b1, 32'h1234_52B7);
        drain();
        check("lui_err_cnt", {24'b0, err_cnt}, modelErrCnt);

        // Backpressure: third request waits until the cycle after the first pop.
        out_ready = 1'b0;
        send(3'b000, 7'h13, 3'd0, 5'd2, 5'd3, 5'd0, 32'd5, 1'b1, 32'h0051_8113);
        send(3'b010, 7'h23, 3'd2, 5'd0, 5'd2, 5'd7, 32'd12, 1'b1, 32'h0071_2623);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        popCyc.delete();
        fork
            send(3'b001, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF0, 1'b1, 32'hFF1F_F06F);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("third_accept_cycle", lastAcceptCyc, (popCyc.size() > 0) ? popCyc[0] + 1 : 0);
        drain();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        send(3'b011, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
        send(3'b011, 7'h63, 3'd1, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        sb.delete();
        modelErrCnt = 0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Saturation of the error counter.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++)
            send(3'b011, 7'h63, 3'($urandom), 5'd0, 5'($urandom), 5'($urandom), 32'd3, 1'b0, 32'h0);
        drain();
        check("err_cnt_saturated", {24'b0, err_cnt}, modelErrCnt);

        // Random roundtrip with a random consumer.
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    t = 3'($urandom);
                    imm = $urandom;
                    if ($urandom_range(0, 7) != 0) imm = fitImm(t, imm);
                    send(t, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), imm, 1'b0, 32'h0);
                end
                stopTog = 1'b1;
            end
            begin
                while (!stopTog) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("random_err_cnt", {24'b0, err_cnt}, modelErrCnt);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_inst_imm_encoder.md
# ysyx_24100006_inst_imm_encoder

Packs RV32I instruction fields and a 32-bit immediate into a 32-bit instruction word, the inverse of the ID-stage immediate extraction. It serves the debug/program-buffer path, which synthesizes instructions such as `jal`, `lui`, `addi` and `sw` for injection into fetch. Requests arrive on a valid/ready handshake, are encoded and range-checked, and are queued in a 2-entry output FIFO that drains on a second valid/ready handshake.

## Interface
Parameters: none.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_imm_type` input 3: immediate type. Same encoding as ID: 000 I, 001 J, 010 S, 011 B, 1xx U.
- `in_opcode` input 7: placed at inst[6:0].
- `in_funct3` input 3: placed at inst[14:12] for I/S/B types.
- `in_rd` input 5: placed at inst[11:7] for I/J/U types.
- `in_rs1` input 5: placed at inst[19:15] for I/S/B types.
- `in_rs2` input 5: placed at inst[24:20] for S/B types.
- `in_imm` input 32: full signed/byte immediate, as ID would produce it.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer pops the head on `out_valid && out_ready`.
- `out_inst` output 32: encoded instruction at the FIFO head.
- `out_err` output 1: the head entry failed its range check.
- `err_cnt` output 8: saturating count of accepted requests that failed the range check.

## Operation
Field packing (the reverse of ID sext):
- I: inst[31:20]=imm[11:0].
- S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
- B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
- J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
- U: inst[31:12]=imm[31:12].

Range rules (error when violated):
- I and S: imm[31:11] must be all equal.
- B: imm[31:12] must be all equal and imm[0] must be 0.
- J: imm[31:20] must be all equal and imm[0] must be 0.
- U: imm[11:0] must be 0.
- On error, the word is still packed from the truncated bits and `out_err`=1 travels with that entry.

FIFO:
- 2 entries, each holding {inst, err}. Occupancy counter `count` ranges 0..2.
- `in_ready` = (`count` != 2), a registered-state decode.
- Push on accept; pop on `out_valid && out_ready`.
- Simultaneous push and pop at `count`=1 leaves `count` unchanged. The FIFO stays in order.
- Pop at `count`=0 is impossible because `out_valid`=0.
- Read and write pointers are 1 bit and wrap naturally.

`err_cnt` increments on each accepted erroneous request and saturates at 255.

## Timing
- Reset values: `count`=0, `out_valid`=0, `out_inst`=0, `out_err`=0, `err_cnt`=0, `in_ready`=1.
- Latency: a request accepted at edge N is visible at the head (`out_valid`=1) after edge N when the FIFO was empty. There is no combinational in->out path.
- `out_inst`/`out_err` are held stable while `out_valid && !out_ready`.
- Full (`count`=2): `in_ready`=0, and no push occurs even if `out_ready`=1 in the same cycle. `in_ready` rises the cycle after the pop.
- Reset mid-operation: all entries are discarded immediately (asynchronously), and `err_cnt` is cleared.
- `in_*` fields are sampled only on the accept edge.

## Configuration
- `YSYX_24100006_IMM_CHECK_EN` defined: range rules above are enforced, and `out_err`/`err_cnt` are live.
- Undefined: no range checking. `out_err` is tied to 0, `err_cnt` is tied to 0, and the FIFO stores only inst. Packing and handshake behaviour are unchanged.

## Test plan
- I-type `addi x1,x0,-1` (opcode 0x13, funct3 0, rd 1, rs1 0, imm 0xFFFFFFFF) -> `out_inst`=0xFFF00093, `out_err`=0, one cycle after accept.
- J-type `jal x1,8` (opcode 0x6F, rd 1, imm 8) -> 0x008000EF. B-type `beq x0,x0,-4` (opcode 0x63, funct3 0, imm 0xFFFFFFFC) -> 0xFE000EE3.
- U-type `lui x5,0x12345` (opcode 0x37, rd 5, imm 0x12345000) -> 0x123452B7. Same request with imm 0x12345001 -> `out_err`=1 and `err_cnt`=1 (with CHECK_EN).
- Backpressure: hold `out_ready`=0 and push 3 requests -> `in_ready`=0 after 2 accepts. Raise `out_ready` -> entries pop in order, and the third request is accepted the cycle after the first pop.
- Assert `reset` while `count`=2 -> `out_valid`=0, `in_ready`=1, `err_cnt`=0 immediately. Drive 300 erroneous requests (B-type, imm=3) -> `err_cnt` saturates at 255.
- Random roundtrip over all types with in-range immediates: decode `out_inst` with the ID immediate extractor -> must equal `in_imm`, and `out_err`=0.
